// File: rtl/dmux_n_hs_if.sv
// dmux_n_hs_if: producer-side and consumer-side stream signals of the
// N-way demultiplexer, bundled so the block and its environment share one view.
interface dmux_n_hs_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;

    // Environment side: drives the producer beat and the consumer readies.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/dmux_n_hs.sv
// dmux_n_hs: N-output valid/ready demultiplexer with a single output register,
// select or round-robin routing, a sticky bad-select flag and saturating
// per-channel beat counters.
module dmux_n_hs #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmux_n_hs_if.slave    bus,
    input  logic          mode,
    input  logic          cnt_clr,
    input  logic [SW-1:0] cnt_sel,
    output logic [CW-1:0] cnt_val,
    output logic          err
);
    // Channel count widened by one bit so N = 2^SW still compares correctly.
    localparam logic [SW:0]   NUM_CH  = N[SW:0];
    localparam int            LAST    = N - 1;
    localparam logic [SW-1:0] LAST_CH = LAST[SW-1:0];

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    logic [W-1:0]  data_q;
    logic [N-1:0]  valid_q;
    logic [SW-1:0] rr_q;
    logic [CW-1:0] cnt_q [N];

    logic [SW-1:0] next_dest;
    logic [N-1:0]  next_valid;
    logic          in_ready;
    logic          drain;
    logic          accept;
    logic          sel_bad;

    // Handshake decode: the held beat leaves when its own consumer is ready,
    // which also frees the register for a new beat in the same cycle.
    always_comb begin
        drain      = |(valid_q & bus.out_ready);
        in_ready   = (state == EMPTY) || drain;
        accept     = bus.in_valid && in_ready;
        sel_bad    = !mode && ({1'b0, bus.in_sel} >= NUM_CH);
        next_dest  = mode ? rr_q : bus.in_sel;
        next_valid = '0;
        for (int i = 0; i < N; i++) begin
            next_valid[i] = (next_dest == SW'(i));
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

    // Output register FSM; a bad-select beat is swallowed without touching the
    // register, and the round-robin pointer moves only on mode-1 accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            data_q  <= '0;
            valid_q <= '0;
            rr_q    <= '0;
            err     <= 1'b0;
        end else begin
            if (accept && !sel_bad) begin
                state   <= FULL;
                data_q  <= bus.in_data;
                valid_q <= next_valid;
            end else if (drain) begin
                state   <= EMPTY;
                valid_q <= '0;
            end
            if (accept && sel_bad) begin
                err <= 1'b1;
            end
            if (accept && mode) begin
                rr_q <= (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
            end
        end
    end

    // Beat counters: clear wins over a simultaneous drain, and each counter
    // sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (valid_q[i] && bus.out_ready[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Counter read mux; selects beyond the last channel read as zero.
    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_sel == SW'(i)) begin
                cnt_val = cnt_q[i];
            end
        end
    end
endmodule

// File: tb/tb_dmux_n_hs.sv
// tb_dmux_n_hs: directed scenarios plus a randomized soak on two instances,
// a 4-channel/8-bit-counter one (A) and a 3-channel/2-bit-counter one (B).
module tb_dmux_n_hs;
    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    dmux_n_hs_if #(.W(8), .N(4), .SW(2)) a_if ();
    dmux_n_hs_if #(.W(8), .N(3), .SW(2)) b_if ();

    logic       a_mode, a_clr, a_err;
    logic       b_mode, b_clr, b_err;
    logic [1:0] a_csel, b_csel;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    dmux_n_hs #(.W(8), .N(4), .SW(2), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .mode(a_mode), .cnt_clr(a_clr),
        .cnt_sel(a_csel), .cnt_val(a_cnt), .err(a_err)
    );

    dmux_n_hs #(.W(8), .N(3), .SW(2), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .mode(b_mode), .cnt_clr(b_clr),
        .cnt_sel(b_csel), .cnt_val(b_cnt), .err(b_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one holding slot per instance, tracked as plain integers.
    int nch  [2] = '{4, 3};
    int cmax [2] = '{255, 3};
    int m_held [2];
    int m_dest [2];
    int m_data [2];
    int m_rr   [2];
    int m_err  [2];
    int m_cnt  [2][4];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_held[d] = 0; m_dest[d] = 0; m_data[d] = 0; m_rr[d] = 0; m_err[d] = 0;
            for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
        end
    endtask

    function automatic int ready_bit(int ready, int ch);
        return (ready >> ch) & 1;
    endfunction

    function automatic int exp_ready(int d, int ready);
        return (m_held[d] == 0 || ready_bit(ready, m_dest[d]) == 1) ? 1 : 0;
    endfunction

    function automatic int exp_valid(int d);
        return (m_held[d] != 0) ? (1 << m_dest[d]) : 0;
    endfunction

    function automatic int exp_cnt(int d, int sel);
        return (sel < nch[d]) ? m_cnt[d][sel] : 0;
    endfunction

    // Advance one instance's model across a clock edge from the sampled inputs.
    task automatic model_step(input int d, input int valid, input int data, input int sel,
                              input int ready, input int mode, input int clr);
        int acc, dr, bad;
        dr  = (m_held[d] != 0 && ready_bit(ready, m_dest[d]) == 1) ? 1 : 0;
        acc = (valid != 0 && exp_ready(d, ready) == 1) ? 1 : 0;
        bad = (mode == 0 && sel >= nch[d]) ? 1 : 0;
        if (clr != 0) begin
            for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
        end else if (dr != 0 && m_cnt[d][m_dest[d]] < cmax[d]) begin
            m_cnt[d][m_dest[d]] = m_cnt[d][m_dest[d]] + 1;
        end
        if (acc != 0 && bad != 0) m_err[d] = 1;
        if (acc != 0 && bad == 0) begin
            m_held[d] = 1;
            m_dest[d] = (mode != 0) ? m_rr[d] : sel;
            m_data[d] = data;
        end else if (dr != 0) begin
            m_held[d] = 0;
        end
        if (acc != 0 && mode != 0) m_rr[d] = (m_rr[d] + 1) % nch[d];
    endtask

    task automatic tick();
        model_step(0, int'(a_if.in_valid), int'(a_if.in_data), int'(a_if.in_sel),
                   int'(a_if.out_ready), int'(a_mode), int'(a_clr));
        model_step(1, int'(b_if.in_valid), int'(b_if.in_data), int'(b_if.in_sel),
                   int'(b_if.out_ready), int'(b_mode), int'(b_clr));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sel = '0; a_if.out_ready = '1;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sel = '0; b_if.out_ready = '1;
        a_mode = 1'b0; a_clr = 1'b0; a_csel = '0;
        b_mode = 1'b0; b_clr = 1'b0; b_csel = '0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (a_if.out_valid !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", a_if.out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_if.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_if.in_ready);
        end
        checks++;
        if (a_if.out_data !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_data: got %h expected 00", a_if.out_data);
        end
        checks++;
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_err: got %b%b expected 00", a_err, b_err);
        end
        for (int i = 0; i < 4; i++) begin
            a_csel = 2'(i);
            #1;
            checks++;
            if (a_cnt !== 8'd0) begin
                errors++; $display("[TB] FAIL reset_cnt%0d: got %0d expected 0", i, a_cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 8'((k + 1) * 17);
            a_if.in_sel   = 2'(k);
            #1;
            checks++;
            if (a_if.in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL basic_ready%0d: got %b expected 1", k, a_if.in_ready);
            end
            tick();
            checks++;
            if (a_if.out_valid !== 4'(1 << k) || a_if.out_data !== 8'((k + 1) * 17)) begin
                errors++; $display("[TB] FAIL basic_beat%0d: got %b/%h expected %b/%h", k,
                                   a_if.out_valid, a_if.out_data, 4'(1 << k), 8'((k + 1) * 17));
            end
        end
        a_if.in_valid = 1'b0;
        tick();
        checks++;
        if (a_if.out_valid !== 4'b0000) begin
            errors++; $display("[TB] FAIL basic_empty: got %b expected 0000", a_if.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            a_csel = 2'(i);
            #1;
            checks++;
            if (a_cnt !== 8'd1) begin
                errors++; $display("[TB] FAIL basic_cnt%0d: got %0d expected 1", i, a_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_if.out_ready = 4'b1011;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'hA5;
        a_if.in_sel    = 2'd2;
        tick();
        a_if.in_data = 8'h5A;
        a_if.in_sel  = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 4'b0100 || a_if.out_data !== 8'hA5) begin
                errors++; $display("[TB] FAIL bp_stall%0d: got rdy=%b %b/%h expected rdy=0 0100/a5", k,
                                   a_if.in_ready, a_if.out_valid, a_if.out_data);
            end
            tick();
        end
        a_if.out_ready = 4'b1111;
        #1;
        checks++;
        if (a_if.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_nobubble: got %b expected 1", a_if.in_ready);
        end
        tick();
        checks++;
        if (a_if.out_valid !== 4'b0010 || a_if.out_data !== 8'h5A) begin
            errors++; $display("[TB] FAIL bp_second: got %b/%h expected 0010/5a", a_if.out_valid, a_if.out_data);
        end
        a_if.in_valid = 1'b0;
        tick();
        a_csel = 2'd2;
        #1;
        checks++;
        if (a_cnt !== 8'd1) begin
            errors++; $display("[TB] FAIL bp_cnt2: got %0d expected 1", a_cnt);
        end
    endtask

    task automatic test_round_robin();
        int exp_d [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        a_mode = 1'b1;
        a_if.in_sel = 2'd0;
        for (int k = 0; k < 6; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 8'(k);
            tick();
            checks++;
            if (a_if.out_valid !== 4'(1 << exp_d[k]) || a_if.out_data !== 8'(k)) begin
                errors++; $display("[TB] FAIL rr_beat%0d: got %b/%h expected %b/%h", k,
                                   a_if.out_valid, a_if.out_data, 4'(1 << exp_d[k]), 8'(k));
            end
        end
        a_mode = 1'b0; a_if.in_sel = 2'd3; a_if.in_data = 8'h06;
        tick();
        checks++;
        if (a_if.out_valid !== 4'b1000) begin
            errors++; $display("[TB] FAIL rr_mode0: got %b expected 1000", a_if.out_valid);
        end
        a_mode = 1'b1; a_if.in_sel = 2'd0; a_if.in_data = 8'h07;
        tick();
        checks++;
        if (a_if.out_valid !== 4'b0100) begin
            errors++; $display("[TB] FAIL rr_resume: got %b expected 0100", a_if.out_valid);
        end
        a_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_invalid_sel();
        do_reset();
        b_if.in_valid = 1'b1; b_if.in_sel = 2'd3; b_if.in_data = 8'hFF;
        #1;
        checks++;
        if (b_if.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_ready: got %b expected 1", b_if.in_ready);
        end
        tick();
        checks++;
        if (b_if.out_valid !== 3'b000 || b_err !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_accept: got %b err=%b expected 000 err=1", b_if.out_valid, b_err);
        end
        b_if.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (b_err !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_sticky: got %b expected 1", b_err);
        end
        b_if.in_valid = 1'b1; b_if.in_sel = 2'd0; b_if.in_data = 8'h3C;
        tick();
        checks++;
        if (b_if.out_valid !== 3'b001 || b_if.out_data !== 8'h3C || b_err !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_next: got %b/%h err=%b expected 001/3c err=1",
                               b_if.out_valid, b_if.out_data, b_err);
        end
        b_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_counters();
        do_reset();
        b_if.in_sel = 2'd1;
        b_csel = 2'd1;
        for (int k = 0; k < 5; k++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = 8'(k);
            tick();
            checks++;
            if (b_cnt !== 2'((k < 3) ? k : 3)) begin
                errors++; $display("[TB] FAIL cnt_step%0d: got %0d expected %0d", k, b_cnt, (k < 3) ? k : 3);
            end
        end
        b_if.in_valid = 1'b0;
        tick();
        checks++;
        if (b_cnt !== 2'd3) begin
            errors++; $display("[TB] FAIL cnt_sat: got %0d expected 3", b_cnt);
        end
        b_if.in_valid = 1'b1; b_if.in_data = 8'h05;
        tick();
        b_if.in_valid = 1'b0; b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        checks++;
        if (b_cnt !== 2'd0 || b_if.out_valid !== 3'b000) begin
            errors++; $display("[TB] FAIL cnt_clr: got %0d/%b expected 0/000", b_cnt, b_if.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_if.out_ready = 4'b1110;
        a_if.in_valid = 1'b1; a_if.in_sel = 2'd1; a_if.in_data = 8'h77;
        tick();
        a_if.in_sel = 2'd0; a_if.in_data = 8'h88;
        tick();
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b1; b_if.in_sel = 2'd3;
        tick();
        b_if.in_valid = 1'b0;
        a_csel = 2'd1;
        #1;
        checks++;
        if (a_cnt !== 8'd1 || a_if.out_valid !== 4'b0001 || b_err !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_pre: got cnt=%0d %b err=%b expected cnt=1 0001 err=1",
                               a_cnt, a_if.out_valid, b_err);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (a_if.out_valid !== 4'b0000 || a_if.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_drop: got %b rdy=%b expected 0000 rdy=1", a_if.out_valid, a_if.in_ready);
        end
        checks++;
        if (a_cnt !== 8'd0 || a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_clear: got cnt=%0d err=%b%b expected 0 00", a_cnt, a_err, b_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            a_if.in_valid  = ($urandom_range(0, 9) < 7);
            a_if.in_data   = 8'($urandom);
            a_if.in_sel    = 2'($urandom_range(0, 3));
            a_if.out_ready = 4'($urandom);
            if ($urandom_range(0, 9) == 0) a_mode = ~a_mode;
            a_clr  = ($urandom_range(0, 19) == 0);
            a_csel = 2'($urandom_range(0, 3));
            b_if.in_valid  = ($urandom_range(0, 9) < 7);
            b_if.in_data   = 8'($urandom);
            b_if.in_sel    = 2'($urandom_range(0, 3));
            b_if.out_ready = 3'($urandom);
            if ($urandom_range(0, 9) == 0) b_mode = ~b_mode;
            b_clr  = ($urandom_range(0, 19) == 0);
            b_csel = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if (a_if.in_ready !== 1'(exp_ready(0, int'(a_if.out_ready))) ||
                b_if.in_ready !== 1'(exp_ready(1, int'(b_if.out_ready)))) begin
                errors++; $display("[TB] FAIL rnd_ready@%0d: got %b%b expected %0d%0d", c, a_if.in_ready,
                                   b_if.in_ready, exp_ready(0, int'(a_if.out_ready)), exp_ready(1, int'(b_if.out_ready)));
            end
            tick();
            checks++;
            if (a_if.out_valid !== 4'(exp_valid(0)) || b_if.out_valid !== 3'(exp_valid(1))) begin
                errors++; $display("[TB] FAIL rnd_valid@%0d: got %b/%b expected %b/%b", c, a_if.out_valid,
                                   b_if.out_valid, 4'(exp_valid(0)), 3'(exp_valid(1)));
            end
            if (m_held[0] != 0) begin
                checks++;
                if (a_if.out_data !== 8'(m_data[0])) begin
                    errors++; $display("[TB] FAIL rnd_data_a@%0d: got %h expected %h", c, a_if.out_data, 8'(m_data[0]));
                end
            end
            if (m_held[1] != 0) begin
                checks++;
                if (b_if.out_data !== 8'(m_data[1])) begin
                    errors++; $display("[TB] FAIL rnd_data_b@%0d: got %h expected %h", c, b_if.out_data, 8'(m_data[1]));
                end
            end
            checks++;
            if (a_err !== 1'(m_err[0]) || b_err !== 1'(m_err[1])) begin
                errors++; $display("[TB] FAIL rnd_err@%0d: got %b%b expected %0d%0d", c, a_err, b_err, m_err[0], m_err[1]);
            end
            checks++;
            if (a_cnt !== 8'(exp_cnt(0, int'(a_csel))) || b_cnt !== 2'(exp_cnt(1, int'(b_csel)))) begin
                errors++; $display("[TB] FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", c, a_cnt, b_cnt,
                                   exp_cnt(0, int'(a_csel)), exp_cnt(1, int'(b_csel)));
            end
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        idle();
        test_reset();
        test_basic();
        test_backpressure();
        test_round_robin();
        test_invalid_sel();
        test_counters();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
